serial_deserializer: RTL and testbench



---
 rtl/serial_deserializer_pkg.sv | 26 ++
 rtl/serial_deserializer_if.sv | 24 ++
 rtl/serial_deserializer_shift_core.sv | 37 +++
 rtl/serial_deserializer.sv | 152 +++++++++++++++
 tb/tb_serial_deserializer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer.
// Optional parity stage is selected by SERDES_PARITY_CHECK_EN (see top).
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_LEFT  = 2'd1,
    SH_RIGHT = 2'd2,
    SH_CLEAR = 2'd3
  } shift_op_e;

  // MSB-first framing fills from bit 0 upward; LSB-first fills from the top down.
  function automatic shift_op_e dir_to_op(input logic dir);
    return (dir == DIR_MSB_FIRST) ? SH_LEFT : SH_RIGHT;
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input / parallel output bundle of the deserializer.
interface serial_deserializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin_valid;
  logic             sin;
  logic             frame_start;
  logic             msb_first;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic             frame_err;
  logic             parity_err;

  modport master (
    output sin_valid, sin, frame_start, msb_first,
    input  q, q_valid, busy, frame_err, parity_err
  );

  modport slave (
    input  sin_valid, sin, frame_start, msb_first,
    output q, q_valid, busy, frame_err, parity_err
  );
endinterface

// File: rtl/serial_deserializer_shift_core.sv
// SIPO shift register with hold / shift-left / shift-right / clear controls.
// word_c is the value the register takes on the coming edge.
module sipo_shift_core
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  shift_op_e        op,
  input  logic             sin,
  output logic [WIDTH-1:0] word_c
);

  logic [WIDTH-1:0] data;

  // Next-value selection for the shift register.
  always_comb begin
    word_c = data;
    case (op)
      SH_LEFT:  word_c = {data[WIDTH-2:0], sin};
      SH_RIGHT: word_c = {sin, data[WIDTH-1:1]};
      SH_CLEAR: word_c = '0;
      default:  word_c = data;
    endcase
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else begin
      data <= word_c;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in / parallel-out receiver: assembles framed bits into WIDTH-bit words.
// Define SERDES_PARITY_CHECK_EN to append an even-parity bit to every frame.
module serial_deserializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_deserializer_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             dir, dir_next;
  logic [WIDTH-1:0] q_r, q_next;
  logic             q_valid_r, q_valid_next;
  logic             busy_r;
  logic             frame_err_r, frame_err_next;
  logic             parity_err_r, parity_err_next;
  shift_op_e        op_c;
  logic [WIDTH-1:0] word_c;
  logic             start_c;

  assign start_c = bus.sin_valid & bus.frame_start;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .op     (op_c),
    .sin    (bus.sin),
    .word_c (word_c)
  );

  // Shift-register control; a frame start always uses the fresh direction.
  always_comb begin
    op_c = SH_HOLD;
    case (state)
      ST_IDLE: begin
        op_c = start_c ? dir_to_op(bus.msb_first) : SH_CLEAR;
      end
      ST_SHIFT: begin
        if (start_c) begin
          op_c = dir_to_op(bus.msb_first);
        end else if (bus.sin_valid) begin
          op_c = dir_to_op(dir);
        end
      end
`ifdef SERDES_PARITY_CHECK_EN
      ST_PARITY: begin
        if (start_c) begin
          op_c = dir_to_op(bus.msb_first);
        end
      end
`endif
      default: op_c = SH_HOLD;
    endcase
  end

  // Frame FSM next state, bit counter and output updates.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    dir_next        = dir;
    q_next          = q_r;
    q_valid_next    = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_c) begin
          dir_next   = bus.msb_first;
          cnt_next   = CW'(1);
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start_c) begin
          frame_err_next = 1'b1;
          dir_next       = bus.msb_first;
          cnt_next       = CW'(1);
        end else if (bus.sin_valid) begin
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERDES_PARITY_CHECK_EN
            cnt_next   = CW'(WIDTH);
            state_next = ST_PARITY;
`else
            q_next       = word_c;
            q_valid_next = 1'b1;
            cnt_next     = '0;
            state_next   = ST_IDLE;
`endif
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
`ifdef SERDES_PARITY_CHECK_EN
      ST_PARITY: begin
        if (start_c) begin
          frame_err_next = 1'b1;
          dir_next       = bus.msb_first;
          cnt_next       = CW'(1);
          state_next     = ST_SHIFT;
        end else if (bus.sin_valid) begin
          q_next          = word_c;
          q_valid_next    = 1'b1;
          parity_err_next = (^word_c) ^ bus.sin;
          cnt_next        = '0;
          state_next      = ST_IDLE;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      dir          <= DIR_LSB_FIRST;
      q_r          <= '0;
      q_valid_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      dir          <= dir_next;
      q_r          <= q_next;
      q_valid_r    <= q_valid_next;
      busy_r       <= (state_next != ST_IDLE);
      frame_err_r  <= frame_err_next;
      parity_err_r <= parity_err_next;
    end
  end

  assign bus.q          = q_r;
  assign bus.q_valid    = q_valid_r;
  assign bus.busy       = busy_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.parity_err = parity_err_r;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (default or SERDES_PARITY_CHECK_EN build).
module tb_serial_deserializer;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         perr;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   fe_q[$];
  exp_t mon_e;

  serial_deserializer_if #(.WIDTH(W)) bus ();

  serial_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.q_valid) begin
        if (exp_q.size() == 0) begin
          check("q_valid_unexpected", 32'(bus.q_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("q", 32'(bus.q), 32'(mon_e.q));
          check("parity_err", 32'(bus.parity_err), 32'(mon_e.perr));
          check("q_valid_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("parity_err_idle", 32'(bus.parity_err), 32'd0);
      end
      if (bus.frame_err) begin
        if (fe_q.size() == 0) begin
          check("frame_err_unexpected", 32'(bus.frame_err), 32'd0);
        end else begin
          check("frame_err_cycle", cyc, fe_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic fs, input logic b, input logic m);
    @(posedge clk);
    #1;
    bus.sin_valid   = v;
    bus.frame_start = fs;
    bus.sin         = b;
    bus.msb_first   = m;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Data bits of one frame; flip toggles msb_first after the first bit.
  task automatic send_bits(input logic [W-1:0] word, input logic msb, input logic flip,
                           input logic resync, input logic chk_busy);
    logic b;
    logic m;
    for (int i = 0; i < int'(W); i++) begin
      b = msb ? word[W-1-i] : word[i];
      m = (i == 0 || !flip) ? msb : ~msb;
      drive(1'b1, i == 0, b, m);
      if (i == 0 && resync) fe_q.push_back(cyc + 1);
      if (chk_busy) begin
        @(negedge clk);
        check("busy_in_frame", 32'(bus.busy), (i == 0) ? 32'd0 : 32'd1);
      end
    end
  endtask

  // Closes a frame (good parity when enabled) and records the expected word.
  task automatic finish_frame(input logic [W-1:0] word);
`ifdef SERDES_PARITY_CHECK_EN
    drive(1'b1, 1'b0, ^word, 1'b0);
`endif
    exp_q.push_back('{q: word, perr: 1'b0, cyc: cyc + 1});
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic msb, input logic flip,
                            input logic resync, input logic chk_busy);
    send_bits(word, msb, flip, resync, chk_busy);
    finish_frame(word);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.sin         = 1'b0;
    bus.msb_first   = 1'b0;
    reset           = 1'b0;
    #10;
    reset = 1'b1;
    #1;
    check("reset_q", 32'(bus.q), 32'd0);
    check("reset_q_valid", 32'(bus.q_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_parity_err", 32'(bus.parity_err), 32'd0);

    // MSB-first 1010 with busy tracking, then busy low in the completion cycle.
    send_frame(4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    idle(2);

    // LSB-first 0110, then with msb_first toggled mid-frame.
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame(4'b1100, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Stall: 1,1, three empty cycles (frame_start without valid), then 0,1.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    finish_frame(4'b1101);
    idle(2);

    // Resync after two bits, restarting with 0011.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(4'b0011, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Back-to-back frames: second start lands in the first q_valid cycle.
    send_frame(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    check("q_hold", 32'(bus.q), 32'h6);

    // Reset after two bits of a frame, then a clean 1001.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    #1;
    check("midframe_reset_q", 32'(bus.q), 32'd0);
    check("midframe_reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    send_frame(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

`ifdef SERDES_PARITY_CHECK_EN
    // Bad even parity on 1010 must raise parity_err with q_valid.
    send_bits(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{q: 4'b1010, perr: 1'b1, cyc: cyc + 1});
    idle(2);
`endif

    idle(4);
    check("pending_q_valid", exp_q.size(), 32'd0);
    check("pending_frame_err", fe_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
